// File: rtl/alu_op_sequencer_if.sv
// Control bus between the micro-op sequencer and its front end / ALU datapath.
// Carries program writes, run request, status and the decoded datapath controls.
// No flow control: all signals are single-cycle level/pulse controls.
interface alu_op_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic              ld_a;
  logic              ld_b;
  logic              ld_c;
  logic              ld_r;
  logic              ld_alu_out;
  logic [1:0]        alu_select_a;
  logic [1:0]        alu_select_b;
  logic              alu_op;

  // Front end / software side: loads the program and requests runs.
  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  busy, done, pc, ld_a, ld_b, ld_c, ld_r, ld_alu_out,
           alu_select_a, alu_select_b, alu_op
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output busy, done, pc, ld_a, ld_b, ld_c, ld_r, ld_alu_out,
           alu_select_a, alu_select_b, alu_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose: programmable micro-op sequencer, issues one add/mul ALU op per clock from a small program store.
// Latency: N-op program is busy N cycles starting the cycle after start; done pulses on cycle N+1.
// Backpressure: none; start and prog_we are ignored while a run is in progress (SEQ_SINGLE_STEP_EN adds a step gate).
module alu_op_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  alu_op_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]        DST_R   = 2'd3;
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        prog_q [PROG_DEPTH];
  logic [7:0]        prog_d [PROG_DEPTH];

  logic [7:0]        slot;
  logic              advance;
  logic              busy_c, done_c;
  logic              ld_a_c, ld_b_c, ld_c_c, ld_r_c, ld_alu_out_c;
  logic [1:0]        sel_a_c, sel_b_c;
  logic              alu_op_c;

  // In single-step mode a RUN op only commits (loads + pc advance) on a step cycle.
`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign slot = prog_q[pc_q];

  // Next-state, program-store write and combinational decode of the current slot.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    prog_d       = prog_q;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    ld_a_c       = 1'b0;
    ld_b_c       = 1'b0;
    ld_c_c       = 1'b0;
    ld_r_c       = 1'b0;
    ld_alu_out_c = 1'b0;
    sel_a_c      = 2'd0;
    sel_b_c      = 2'd0;
    alu_op_c     = 1'b0;

    // Program is frozen during a run so every op of a run comes from one program image.
    if (bus.prog_we && (state_q != ST_RUN)) begin
      prog_d[bus.prog_addr] = bus.prog_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        busy_c       = 1'b1;
        sel_a_c      = slot[5:4];
        sel_b_c      = slot[3:2];
        alu_op_c     = slot[1];
        ld_alu_out_c = (slot[7:6] != DST_R);
        ld_a_c       = advance && (slot[7:6] == 2'd0);
        ld_b_c       = advance && (slot[7:6] == 2'd1);
        ld_c_c       = advance && (slot[7:6] == 2'd2);
        ld_r_c       = advance && (slot[7:6] == DST_R);
        if (advance) begin
          // The last slot terminates even without its last bit: pc never wraps.
          if (slot[0] || (pc_q == PC_LAST)) begin
            state_d = ST_DONE;
            pc_d    = '0;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        pc_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State, pc and program registers; reset restores the single-op default program.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      prog_q  <= '{default: 8'h01};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prog_q  <= prog_d;
    end
  end

  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.pc           = pc_q;
  assign bus.ld_a         = ld_a_c;
  assign bus.ld_b         = ld_b_c;
  assign bus.ld_c         = ld_c_c;
  assign bus.ld_r         = ld_r_c;
  assign bus.ld_alu_out   = ld_alu_out_c;
  assign bus.alu_select_a = sel_a_c;
  assign bus.alu_select_b = sel_b_c;
  assign bus.alu_op       = alu_op_c;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural A/B/C/X/R datapath driven by the DUT controls.
// Expected results are hand-computed constants.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;

  alu_op_sequencer_if #(.ADDR_W(3)) bus ();

  alu_op_sequencer #(.PROG_DEPTH(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: front end preloads A/B/C/X, otherwise the sequencer controls loads.
  logic       fe_ld;
  logic [7:0] fe_a, fe_b, fe_c, fe_x, data_in;
  logic [7:0] ra, rb, rc, rx, rr;
  logic [7:0] opa, opb, alu_res;

  always_comb begin
    case (bus.alu_select_a)
      2'd0: opa = ra;
      2'd1: opa = rb;
      2'd2: opa = rc;
      default: opa = rx;
    endcase
    case (bus.alu_select_b)
      2'd0: opb = ra;
      2'd1: opb = rb;
      2'd2: opb = rc;
      default: opb = rx;
    endcase
    alu_res = bus.alu_op ? 8'(opa * opb) : 8'(opa + opb);
  end

  always @(posedge clk) begin
    if (fe_ld) begin
      ra <= fe_a; rb <= fe_b; rc <= fe_c; rx <= fe_x;
    end else begin
      if (bus.ld_a) ra <= bus.ld_alu_out ? alu_res : data_in;
      if (bus.ld_b) rb <= bus.ld_alu_out ? alu_res : data_in;
      if (bus.ld_c) rc <= bus.ld_alu_out ? alu_res : data_in;
      if (bus.ld_r) rr <= alu_res;
    end
  end

  int n_checks;
  int n_fail;

  logic [2:0]  pc_trace [16];
  logic [10:0] ld_trace [16];

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic write_slot(input logic [2:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic load_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
    fe_ld = 1'b1; fe_a = a; fe_b = b; fe_c = c; fe_x = x;
    @(posedge clk); #1;
    fe_ld = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Watches a fixed number of cycles (cycle 1 = first cycle after start) and records activity.
  task automatic observe(input int budget, output int nbusy, output int ndone, output int done_cyc);
    nbusy = 0; ndone = 0; done_cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (nbusy < 16) begin
          pc_trace[nbusy] = bus.pc;
          ld_trace[nbusy] = {bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_r, bus.ld_alu_out,
                             bus.alu_select_a, bus.alu_select_b, bus.alu_op};
        end
        nbusy++;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [10:0] ctl;
    @(negedge clk);
    ctl = {bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_r, bus.ld_alu_out, bus.alu_select_a, bus.alu_select_b, bus.alu_op};
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.pc !== 3'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.pc); end
    n_checks++; if (ctl !== 11'd0) begin n_fail++; $display("FAIL reset_ctl: got %b want all zero", ctl); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_default_program();
    int nb, nd, dc;
    load_regs(8'd7, 8'd0, 8'd0, 8'd0);
    start_run();
    observe(5, nb, nd, dc);
    n_checks++; if (ra !== 8'd14) begin n_fail++; $display("FAIL default_slot_A: got %0d want 14", ra); end
    n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL default_busy_len: got %0d want 1", nb); end
    n_checks++; if (dc !== 2) begin n_fail++; $display("FAIL default_done_cycle: got %0d want 2", dc); end
  endtask

  task automatic test_poly();
    int nb, nd, dc;
    write_slot(3'd0, 8'h32);   // A <= X*A
    write_slot(3'd1, 8'h32);   // A <= X*A
    write_slot(3'd2, 8'h5E);   // B <= B*X
    write_slot(3'd3, 8'h04);   // A <= A+B
    write_slot(3'd4, 8'hC9);   // R <= A+C, last
    load_regs(8'd3, 8'd4, 8'd5, 8'd2);
    start_run();
    observe(9, nb, nd, dc);
    n_checks++; if (rr !== 8'h19) begin n_fail++; $display("FAIL poly_result: got %h want 19", rr); end
    n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL poly_busy_len: got %0d want 5", nb); end
    n_checks++; if (dc !== 6) begin n_fail++; $display("FAIL poly_done_cycle: got %0d want 6", dc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL poly_done_count: got %0d want 1", nd); end
    n_checks++; if (ld_trace[0] !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1})
      begin n_fail++; $display("FAIL poly_decode_op0: got %b want 10001110001", ld_trace[0]); end
    n_checks++; if (ld_trace[2] !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 1'b1})
      begin n_fail++; $display("FAIL poly_decode_op2: got %b want 01001011111", ld_trace[2]); end
    n_checks++; if (pc_trace[4] !== 3'd4) begin n_fail++; $display("FAIL poly_pc_last: got %0d want 4", pc_trace[4]); end
  endtask

  task automatic test_single_op();
    int nb, nd, dc;
    write_slot(3'd0, 8'hC5);   // R <= A+B, last
    load_regs(8'hF0, 8'h20, 8'd0, 8'd0);
    start_run();
    observe(5, nb, nd, dc);
    n_checks++; if (rr !== 8'h10) begin n_fail++; $display("FAIL single_result: got %h want 10", rr); end
    n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL single_busy_len: got %0d want 1", nb); end
    n_checks++; if (ld_trace[0] !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0})
      begin n_fail++; $display("FAIL single_decode: got %b want 00010000010", ld_trace[0]); end
  endtask

  task automatic test_prog_we_busy();
    int nb, nd, dc;
    start_run();
    bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 8'hC7;   // would turn add into mul
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL we_busy_running: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
    @(posedge clk); #1;
    start_run();
    observe(4, nb, nd, dc);
    n_checks++; if (rr !== 8'h10) begin n_fail++; $display("FAIL we_busy_rerun: got %h want 10", rr); end
  endtask

  task automatic test_start_and_write();
    int nb, nd, dc;
    bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 8'hC7;   // R <= A*B, last
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.prog_we = 1'b0; bus.start = 1'b0;
    observe(4, nb, nd, dc);
    n_checks++; if (rr !== 8'h00) begin n_fail++; $display("FAIL start_write_result: got %h want 00", rr); end
    n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL start_write_busy_len: got %0d want 1", nb); end
  endtask

  task automatic test_start_held();
    int nb, nd, viol;
    logic prev_done;
    write_slot(3'd0, 8'hC5);
    nb = 0; nd = 0; viol = 0; prev_done = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 20) bus.start = 1'b0;
      @(negedge clk);
      if (bus.busy === 1'b1) nb++;
      if (bus.done === 1'b1) nd++;
      if ((bus.busy === 1'b1) && (bus.done === 1'b1)) viol++;
      if (prev_done && (bus.busy === 1'b1)) viol++;
      prev_done = bus.done;
    end
    @(posedge clk); #1;
    n_checks++; if (nd !== 7) begin n_fail++; $display("FAIL held_done_count: got %0d want 7", nd); end
    n_checks++; if (nb !== 7) begin n_fail++; $display("FAIL held_busy_count: got %0d want 7", nb); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL held_restart_gap: got %0d violations want 0", viol); end
  endtask

  task automatic test_no_last();
    int nb, nd, dc;
    for (int i = 0; i < 8; i++) write_slot(3'(i), 8'h50);   // B <= B+A, no last bit
    load_regs(8'd3, 8'd0, 8'd0, 8'd0);
    start_run();
    observe(12, nb, nd, dc);
    n_checks++; if (nb !== 8) begin n_fail++; $display("FAIL nolast_busy_len: got %0d want 8", nb); end
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL nolast_done_cycle: got %0d want 9", dc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL nolast_done_count: got %0d want 1", nd); end
    n_checks++; if (rb !== 8'd24) begin n_fail++; $display("FAIL nolast_result: got %0d want 24", rb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (pc_trace[i] !== 3'(i)) begin n_fail++; $display("FAIL nolast_pc[%0d]: got %0d want %0d", i, pc_trace[i], i); end
    end
    @(negedge clk);
    n_checks++; if (bus.pc !== 3'd0) begin n_fail++; $display("FAIL nolast_idle_pc: got %0d want 0", bus.pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int nb, nd, dc;
    load_regs(8'd3, 8'd0, 8'd0, 8'd0);
    start_run();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.ld_b !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_ldb: got %b want 1", bus.ld_b); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", bus.busy); end
    n_checks++; if ({bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_r} !== 4'b0000)
      begin n_fail++; $display("FAIL midrun_loads: got %b want 0000", {bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_r}); end
    @(posedge clk); #1;
    reset = 1'b0;
    observe(5, nb, nd, dc);
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d want 0", nd); end
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL midrun_stays_idle: got %0d want 0", nb); end
    load_regs(8'd5, 8'd0, 8'd0, 8'd0);
    start_run();
    observe(4, nb, nd, dc);
    n_checks++; if (ra !== 8'd10) begin n_fail++; $display("FAIL midrun_slots_cleared: got %0d want 10", ra); end
    n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL midrun_cleared_len: got %0d want 1", nb); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = 3'd0; bus.prog_data = 8'h00; bus.start = 1'b0;
    fe_ld = 1'b0; fe_a = 8'd0; fe_b = 8'd0; fe_c = 8'd0; fe_x = 8'd0; data_in = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_default_program();
    test_poly();
    test_single_op();
    test_prog_we_busy();
    test_start_and_write();
    test_start_held();
    test_no_last();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
